// File: rtl/dbl_frame_buffer.sv
// Double-buffered frame store: the GPU and clear engine write the back page, and VGA reads the front page.
// A requested page flip is committed only on frame_start while the clear engine is idle.
module dbl_frame_buffer #(
    parameter int PIXEL_W = 4,
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int DEPTH   = H_RES * V_RES,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               gpu_clk,
    input  logic               gpu_rst_n,
    input  logic [PIXEL_W-1:0] gpu_pixel_data,
    input  logic [ADDR_W-1:0]  gpu_pixel_addr,
    input  logic               gpu_we,
    output logic               gpu_ready,
    input  logic               clear_req,
    input  logic [PIXEL_W-1:0] clear_color,
    input  logic               swap_req,
    input  logic               frame_start,
    output logic               swap_pending,
    output logic               front_page,
    output logic               busy,
    input  logic [ADDR_W-1:0]  vga_pixel_addr,
    output logic [PIXEL_W-1:0] vga_pixel_data
);

    typedef enum logic {IDLE, CLEAR} state_t;

    // Range checks use one extra bit so they stay meaningful when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q;
    logic [PIXEL_W-1:0] clr_color_q;
    logic               front_q, pending_q;
    logic               commit;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIXEL_W-1:0] wr_data;

    logic [PIXEL_W-1:0] page0 [DEPTH];
    logic [PIXEL_W-1:0] page1 [DEPTH];

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        gpu_ready = 1'b1;
        commit    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = gpu_pixel_addr;
        wr_data   = gpu_pixel_data;
        case (state_q)
            IDLE: begin
                if (clear_req) state_d = CLEAR;
                commit = frame_start && (pending_q || swap_req);
                wr_en  = gpu_we && ({1'b0, gpu_pixel_addr} < DEPTH_X);
            end
            CLEAR: begin
                busy      = 1'b1;
                gpu_ready = 1'b0;
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = clr_color_q;
                if (clr_cnt_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
        if (!gpu_rst_n) begin
            state_q        <= IDLE;
            clr_cnt_q      <= '0;
            clr_color_q    <= '0;
            front_q        <= 1'b0;
            pending_q      <= 1'b0;
            vga_pixel_data <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && clear_req) begin
                clr_cnt_q   <= '0;
                clr_color_q <= clear_color;
            end else if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            if (commit) begin
                front_q   <= ~front_q;
                pending_q <= 1'b0;
            end else if (swap_req) begin
                pending_q <= 1'b1;
            end
            if ({1'b0, vga_pixel_addr} < DEPTH_X)
                vga_pixel_data <= front_q ? page1[vga_pixel_addr] : page0[vga_pixel_addr];
            else
                vga_pixel_data <= '0;
        end
    end

    // Only the back page (~front_q) is ever written, so the read port never collides.
    always_ff @(posedge gpu_clk) begin
        if (wr_en && front_q)  page0[wr_addr] <= wr_data;
        if (wr_en && !front_q) page1[wr_addr] <= wr_data;
    end

    assign front_page   = front_q;
    assign swap_pending = pending_q;

endmodule

// File: tb/tb_dbl_frame_buffer.sv
// Bench for dbl_frame_buffer at 4x2 pixels: directed scenarios followed by random traffic,
// all compared against a page-array reference model.
module tb_dbl_frame_buffer;

    localparam int PW = 4;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          gpu_clk = 1'b0;
    logic          gpu_rst_n = 1'b0;
    logic [PW-1:0] gpu_pixel_data = '0;
    logic [AW-1:0] gpu_pixel_addr = '0;
    logic          gpu_we = 1'b0;
    logic          gpu_ready;
    logic          clear_req = 1'b0;
    logic [PW-1:0] clear_color = '0;
    logic          swap_req = 1'b0;
    logic          frame_start = 1'b0;
    logic          swap_pending;
    logic          front_page;
    logic          busy;
    logic [AW-1:0] vga_pixel_addr = '0;
    logic [PW-1:0] vga_pixel_data;

    dbl_frame_buffer #(.PIXEL_W(PW), .H_RES(4), .V_RES(2)) dut (
        .gpu_clk(gpu_clk), .gpu_rst_n(gpu_rst_n),
        .gpu_pixel_data(gpu_pixel_data), .gpu_pixel_addr(gpu_pixel_addr),
        .gpu_we(gpu_we), .gpu_ready(gpu_ready),
        .clear_req(clear_req), .clear_color(clear_color),
        .swap_req(swap_req), .frame_start(frame_start),
        .swap_pending(swap_pending), .front_page(front_page), .busy(busy),
        .vga_pixel_addr(vga_pixel_addr), .vga_pixel_data(vga_pixel_data)
    );

    always #5 gpu_clk = ~gpu_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: two page arrays, a remaining-fill count and a pending flag.
    int m_page [2][D];
    bit m_val  [2][D];
    int m_front = 0, m_pending = 0, m_left = 0, m_idx = 0, m_color = 0;
    int m_rd = 0;
    bit m_rdk = 1'b1;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mwrite(input int pg, input int a, input int v);
        m_page[pg][a] = v;
        m_val[pg][a]  = 1'b1;
    endtask

    // Advance one clock: update the model from the inputs, sample after the edge, then drop the pulses.
    task automatic step();
        int  back;
        bit  was_busy;
        bit  commit;
        back     = 1 - m_front;
        was_busy = (m_left > 0);
        m_rd     = m_page[m_front][int'(vga_pixel_addr)];
        m_rdk    = m_val[m_front][int'(vga_pixel_addr)];
        if (was_busy) begin
            mwrite(back, m_idx, m_color);
            m_idx++;
            m_left--;
        end else begin
            if (gpu_we) mwrite(back, int'(gpu_pixel_addr), int'(gpu_pixel_data));
            if (clear_req) begin
                m_left  = D;
                m_idx   = 0;
                m_color = int'(clear_color);
            end
        end
        commit = frame_start && !was_busy && (m_pending != 0 || swap_req);
        if (commit) begin
            m_front   = 1 - m_front;
            m_pending = 0;
        end else if (swap_req) begin
            m_pending = 1;
        end
        @(posedge gpu_clk);
        #1;
        gpu_we = 1'b0; clear_req = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
        check("busy", int'(busy), int'(m_left > 0));
        check("gpu_ready", int'(gpu_ready), int'(m_left == 0));
        check("front_page", int'(front_page), m_front);
        check("swap_pending", int'(swap_pending), m_pending);
        if (m_rdk) check("vga_data", int'(vga_pixel_data), m_rd);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && busy; i++) step();
        check(tag, int'(busy), 0);
    endtask

    initial begin
        int cnt;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < D; a++) begin
                m_page[p][a] = 0;
                m_val[p][a]  = 1'b0;
            end

        // Reset values
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(gpu_ready), 1);
        check("rst_front", int'(front_page), 0);
        check("rst_pending", int'(swap_pending), 0);
        check("rst_vga", int'(vga_pixel_data), 0);
        #9 gpu_rst_n = 1'b1;

        // Fill both pages with 0 so all later reads are defined
        clear_color = 4'h0; clear_req = 1'b1; step();
        wait_idle("init_clr1");
        swap_req = 1'b1; frame_start = 1'b1; step();
        clear_req = 1'b1; step();
        wait_idle("init_clr2");
        swap_req = 1'b1; frame_start = 1'b1; step();
        check("init_front", int'(front_page), 0);

        // Write to back page is invisible until the flip
        gpu_we = 1'b1; gpu_pixel_addr = 3'd5; gpu_pixel_data = 4'hA; vga_pixel_addr = 3'd5;
        step(); step();
        check("t1_old", int'(vga_pixel_data), 0);
        swap_req = 1'b1; step();
        frame_start = 1'b1; step();
        check("t1_front", int'(front_page), 1);
        step();
        check("t1_new", int'(vga_pixel_data), 'hA);

        // Pending swap waits for frame_start
        swap_req = 1'b1; step();
        for (int i = 0; i < 100; i++) step();
        check("t2_pending", int'(swap_pending), 1);
        check("t2_front", int'(front_page), 1);
        frame_start = 1'b1; step();
        check("t2_flip", int'(front_page), 0);
        check("t2_clr", int'(swap_pending), 0);

        // Clear: 8 busy cycles, GPU writes dropped, then same-cycle swap
        clear_color = 4'h3; clear_req = 1'b1; step();
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            gpu_we = 1'b1; gpu_pixel_addr = 3'(i); gpu_pixel_data = 4'hF;
            step();
            if (busy) cnt++;
        end
        check("t3_busy_len", cnt, 8);
        swap_req = 1'b1; frame_start = 1'b1; step();
        check("t5_front", int'(front_page), 1);
        check("t5_pending", int'(swap_pending), 0);
        for (int i = 0; i < D; i++) begin
            vga_pixel_addr = 3'(i);
            step();
            check("t3_rd", int'(vga_pixel_data), 3);
        end

        // frame_start during CLEAR must not commit
        swap_req = 1'b1; step();
        clear_color = 4'h5; clear_req = 1'b1; step();
        step();
        frame_start = 1'b1; step();
        check("t4_noflip", int'(front_page), 1);
        check("t4_pending", int'(swap_pending), 1);
        wait_idle("t4_idle");
        frame_start = 1'b1; step();
        check("t4_flip", int'(front_page), 0);
        check("t4_pclr", int'(swap_pending), 0);

        // Asynchronous reset mid-clear with a swap pending
        swap_req = 1'b1; frame_start = 1'b1; step();
        swap_req = 1'b1; step();
        clear_color = 4'h9; clear_req = 1'b1; step();
        step(); step();
        #2 gpu_rst_n = 1'b0;
        #1;
        check("ar_busy", int'(busy), 0);
        check("ar_ready", int'(gpu_ready), 1);
        check("ar_front", int'(front_page), 0);
        check("ar_pending", int'(swap_pending), 0);
        check("ar_vga", int'(vga_pixel_data), 0);
        m_front = 0; m_pending = 0; m_left = 0; m_rd = 0; m_rdk = 1'b1;
        #1 gpu_rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            gpu_we         = 1'($urandom_range(0, 1));
            gpu_pixel_addr = 3'($urandom_range(0, 7));
            gpu_pixel_data = 4'($urandom_range(0, 15));
            clear_req      = ($urandom_range(0, 29) == 0);
            clear_color    = 4'($urandom_range(0, 15));
            swap_req       = ($urandom_range(0, 9) == 0);
            frame_start    = ($urandom_range(0, 14) == 0);
            vga_pixel_addr = 3'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
